// File: rtl/schedule_reader.sv
// Streams the DEPTH-entry schedule table from the writer's active BRAM bank over valid/ready,
// repeating frames; the bank is only re-sampled at frame boundaries.
module schedule_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              selMem,
    output logic              rdEn1,
    output logic [ADDR_W-1:0] rdAdd1,
    input  logic [DATA_W-1:0] rdData1,
    output logic              rdEn2,
    output logic [ADDR_W-1:0] rdAdd2,
    input  logic [DATA_W-1:0] rdData2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_bank,
    output logic              bank_switch,
    output logic [CNT_W-1:0]  frame_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_rdAdd1;
    logic [ADDR_W-1:0]   r_rdAdd2;
    logic                r_active_bank;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_first;
    logic                r_out_bank;
    logic                r_bank_switch;
    logic [CNT_W-1:0]    r_frame_count;
    logic                w_accept;
    logic                w_frame_end;
    logic                w_reading;

    assign w_accept    = (r_state == S_HOLD) && r_out_valid && out_ready;
    assign w_frame_end = w_accept && (r_addr == LAST_ADDR);
    assign w_reading   = (r_state == S_READ);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (enable) w_next = S_READ;
            S_READ: w_next = S_CAPT;
            S_CAPT: w_next = S_HOLD;
            S_HOLD: if (w_accept) w_next = enable ? S_READ : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_rdAdd1      <= '0;
            r_rdAdd2      <= '0;
            r_active_bank <= 1'b1;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_first   <= 1'b0;
            r_out_bank    <= 1'b1;
            r_bank_switch <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_next;
            r_bank_switch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Only a fresh frame may pick up a new bank; a paused frame resumes on its own bank.
                    if (enable && (r_addr == '0)) r_active_bank <= selMem;
                end
                S_READ: begin
                    if (r_active_bank) r_rdAdd1 <= r_addr;
                    else               r_rdAdd2 <= r_addr;
                end
                S_CAPT: begin
                    r_out_data  <= r_active_bank ? rdData1 : rdData2;
                    r_out_valid <= 1'b1;
                    r_out_first <= (r_addr == '0);
                    r_out_bank  <= r_active_bank;
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (w_frame_end) begin
                            r_addr        <= '0;
                            r_frame_count <= r_frame_count + 1'b1;
                            r_active_bank <= selMem;
                            r_bank_switch <= (selMem != r_active_bank);
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The live address is presented during READ; afterwards the registered copy holds it.
    assign rdEn1       = w_reading && r_active_bank;
    assign rdEn2       = w_reading && !r_active_bank;
    assign rdAdd1      = (w_reading && r_active_bank) ? r_addr : r_rdAdd1;
    assign rdAdd2      = (w_reading && !r_active_bank) ? r_addr : r_rdAdd2;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_first   = r_out_first;
    assign out_bank    = r_out_bank;
    assign bank_switch = r_bank_switch;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_schedule_reader.sv
// Directed bench for schedule_reader: BRAM1[i]=100+i, BRAM2[i]=200+i, 2-bit frame counter.
module tb_schedule_reader;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 6;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          selMem = 1'b1;
    logic          out_ready = 1'b1;
    logic          rdEn1, rdEn2;
    logic [AW-1:0] rdAdd1, rdAdd2;
    logic [DW-1:0] rdData1 = '0;
    logic [DW-1:0] rdData2 = '0;
    logic          out_valid, out_first, out_bank, bank_switch;
    logic [DW-1:0] out_data;
    logic [CW-1:0] frame_count;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned c1 = 0;
    int unsigned c2 = 0;

    schedule_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .selMem(selMem),
        .rdEn1(rdEn1), .rdAdd1(rdAdd1), .rdData1(rdData1),
        .rdEn2(rdEn2), .rdAdd2(rdAdd2), .rdData2(rdData2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_bank(out_bank),
        .bank_switch(bank_switch), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // BRAM models with 1-cycle read latency; also count read strobes per bank.
    always @(posedge clk) begin
        if (rdEn1) begin
            rdData1 <= 32'd100 + rdAdd1;
            c1 <= c1 + 1;
        end
        if (rdEn2) begin
            rdData2 <= 32'd200 + rdAdd2;
            c2 <= c2 + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; selMem = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({out_valid, out_first, out_bank, bank_switch, rdEn1, rdEn2} !== 6'b001000)
            $display("FAIL reset_flags actual=%b required=001000",
                     {out_valid, out_first, out_bank, bank_switch, rdEn1, rdEn2});
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset_data actual=%0d required=0", out_data);
        else n_pass++;
        n_checks++;
        if (frame_count !== '0) $display("FAIL reset_fc actual=%0d required=0", frame_count);
        else n_pass++;
        n_checks++;
        if ({rdAdd1, rdAdd2} !== '0) $display("FAIL reset_addr actual=%0d/%0d required=0/0", rdAdd1, rdAdd2);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        bit ok;
        for (int i = 0; i < DEPTH; i++) begin
            wait_valid(ok);
            n_checks++;
            if (!ok) $display("FAIL basic_timeout entry=%0d actual=no_valid required=valid", i);
            else n_pass++;
            n_checks++;
            if (out_data !== DW'(100 + i)) $display("FAIL basic_data actual=%0d required=%0d", out_data, 100 + i);
            else n_pass++;
            n_checks++;
            if ({out_first, out_bank} !== {(i == 0), 1'b1})
                $display("FAIL basic_first_bank entry=%0d actual=%b required=%b", i, {out_first, out_bank}, {(i == 0), 1'b1});
            else n_pass++;
            tick();
        end
        n_checks++;
        if (frame_count !== 2'd1) $display("FAIL basic_fc actual=%0d required=1", frame_count);
        else n_pass++;
        n_checks++;
        if (bank_switch !== 1'b0) $display("FAIL basic_switch actual=%b required=0", bank_switch);
        else n_pass++;
    endtask

    task automatic test_bank_switch();
        bit ok;
        int unsigned c1s, c2s;
        for (int i = 0; i < DEPTH; i++) begin
            wait_valid(ok);
            if (i == 3) selMem = 1'b0;
            n_checks++;
            if (!ok || out_data !== DW'(100 + i) || out_bank !== 1'b1)
                $display("FAIL switch_old_bank entry=%0d actual=%0d/%b required=%0d/1", i, out_data, out_bank, 100 + i);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (bank_switch !== 1'b1) $display("FAIL switch_pulse actual=%b required=1", bank_switch);
        else n_pass++;
        n_checks++;
        if (frame_count !== 2'd2) $display("FAIL switch_fc actual=%0d required=2", frame_count);
        else n_pass++;
        c1s = c1; c2s = c2;
        tick();
        n_checks++;
        if (bank_switch !== 1'b0) $display("FAIL switch_pulse_width actual=%b required=0", bank_switch);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            wait_valid(ok);
            n_checks++;
            if (!ok || out_data !== DW'(200 + i) || {out_first, out_bank} !== {(i == 0), 1'b0})
                $display("FAIL switch_new_bank entry=%0d actual=%0d/%b required=%0d/%b",
                         i, out_data, {out_first, out_bank}, 200 + i, {(i == 0), 1'b0});
            else n_pass++;
            tick();
        end
        n_checks++;
        if (c1 != c1s || c2 - c2s != 6)
            $display("FAIL switch_rden actual=%0d/%0d required=0/6", c1 - c1s, c2 - c2s);
        else n_pass++;
        n_checks++;
        if (frame_count !== 2'd3) $display("FAIL switch_fc2 actual=%0d required=3", frame_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        logic [DW-1:0] d;
        int unsigned cs;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 2) out_ready = 1'b0;
            wait_valid(ok);
            n_checks++;
            if (!ok || out_data !== DW'(200 + i))
                $display("FAIL bp_data entry=%0d actual=%0d required=%0d", i, out_data, 200 + i);
            else n_pass++;
            if (i == 2) begin
                d = out_data; cs = c1 + c2; stable = 1'b1;
                repeat (10) begin
                    tick();
                    if (out_valid !== 1'b1 || out_data !== d) stable = 1'b0;
                end
                n_checks++;
                if (!stable) $display("FAIL bp_hold actual=unstable required=stable");
                else n_pass++;
                n_checks++;
                if (c1 + c2 != cs) $display("FAIL bp_no_read actual=%0d required=0", c1 + c2 - cs);
                else n_pass++;
                out_ready = 1'b1;
            end
            tick();
            if (i == 2) begin
                n_checks++;
                if (out_valid !== 1'b0 || c1 + c2 != cs)
                    $display("FAIL bp_accept actual=%b/%0d required=0/0", out_valid, c1 + c2 - cs);
                else n_pass++;
            end
        end
        n_checks++;
        if (frame_count !== 2'd0) $display("FAIL bp_fc_wrap actual=%0d required=0", frame_count);
        else n_pass++;
    endtask

    task automatic test_enable_pause();
        bit ok, quiet;
        int unsigned cs;
        for (int i = 0; i < DEPTH; i++) begin
            wait_valid(ok);
            if (i == 4) enable = 1'b0;
            n_checks++;
            if (!ok || out_data !== DW'(200 + i) || {out_first, out_bank} !== {(i == 0), 1'b0})
                $display("FAIL pause_data entry=%0d actual=%0d/%b required=%0d/%b",
                         i, out_data, {out_first, out_bank}, 200 + i, {(i == 0), 1'b0});
            else n_pass++;
            tick();
            if (i == 4) begin
                cs = c1 + c2; selMem = 1'b1; quiet = 1'b1;
                repeat (6) begin
                    if (out_valid !== 1'b0 || bank_switch !== 1'b0) quiet = 1'b0;
                    tick();
                end
                n_checks++;
                if (!quiet || c1 + c2 != cs)
                    $display("FAIL pause_idle actual=active/%0d required=idle/0", c1 + c2 - cs);
                else n_pass++;
                enable = 1'b1;
            end
        end
        n_checks++;
        if (bank_switch !== 1'b1 || frame_count !== 2'd1)
            $display("FAIL pause_frame_end actual=%b/%0d required=1/1", bank_switch, frame_count);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            wait_valid(ok);
            n_checks++;
            if (!ok || out_data !== DW'(100 + i) || out_bank !== 1'b1)
                $display("FAIL rstmid_pre entry=%0d actual=%0d/%b required=%0d/1", i, out_data, out_bank, 100 + i);
            else n_pass++;
            tick();
        end
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, out_first, out_bank, bank_switch, rdEn1, rdEn2} !== 6'b001000)
            $display("FAIL rstmid_flags actual=%b required=001000",
                     {out_valid, out_first, out_bank, bank_switch, rdEn1, rdEn2});
        else n_pass++;
        n_checks++;
        if (out_data !== '0 || frame_count !== '0 || {rdAdd1, rdAdd2} !== '0)
            $display("FAIL rstmid_values actual=%0d/%0d/%0d/%0d required=0/0/0/0",
                     out_data, frame_count, rdAdd1, rdAdd2);
        else n_pass++;
        selMem = 1'b0;
        rst = 1'b0;
        wait_valid(ok);
        n_checks++;
        if (!ok || out_data !== 32'd200 || {out_first, out_bank} !== 2'b10)
            $display("FAIL rstmid_restart actual=%0d/%b required=200/10", out_data, {out_first, out_bank});
        else n_pass++;
    endtask

    task automatic test_frame_count_wrap();
        bit ok;
        logic [CW-1:0] exp_fc [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wait_valid(ok);
                n_checks++;
                if (!ok || out_data !== DW'(200 + i))
                    $display("FAIL wrap_data frame=%0d entry=%0d actual=%0d required=%0d", f, i, out_data, 200 + i);
                else n_pass++;
                tick();
            end
            n_checks++;
            if (frame_count !== exp_fc[f])
                $display("FAIL wrap_fc frame=%0d actual=%0d required=%0d", f, frame_count, exp_fc[f]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bank_switch();
        test_backpressure();
        test_enable_pause();
        test_reset_midframe();
        test_frame_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
